// File: rtl/spinner_speed_ctrl.sv
// Button-driven speed controller for the 7-segment spinner: synchronises and debounces
// faster/slower buttons, keeps a saturating speed code and issues load commands on change.
module spinner_speed_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_WIDTH       = 10,
    parameter int unsigned REPEAT_CYCLES   = 500000,
    parameter int unsigned REPEAT_WIDTH    = 20,
    parameter logic [3:0]  RESET_SPEED     = 4'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] fn_out,
    output logic [3:0] data_out,
    output logic [3:0] speed
);
    localparam int unsigned SPEED_W = 4;
    localparam int unsigned NUM_BTN = 2;
    localparam logic [CNT_WIDTH-1:0]    DB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [REPEAT_WIDTH-1:0] REP_LAST = REPEAT_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [SPEED_W-1:0]      SPEED_MAX = SPEED_W'(15);
    localparam logic [SPEED_W-1:0]      SPEED_MIN = SPEED_W'(0);
    localparam logic [1:0]              FN_RUN  = 2'b00;
    localparam logic [1:0]              FN_LOAD = 2'b01;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [NUM_BTN-1:0]      raw;
    logic [NUM_BTN-1:0]      meta;
    logic [NUM_BTN-1:0]      sync;
    logic [NUM_BTN-1:0]      db;
    logic [NUM_BTN-1:0]      db_prev;
    logic [NUM_BTN-1:0]      press;
    logic [NUM_BTN-1:0]      rpt_hit;
    logic [NUM_BTN-1:0]      rpt;
    logic [NUM_BTN-1:0]      step;
    logic                    both_held;
    logic [CNT_WIDTH-1:0]    db_cnt  [NUM_BTN];
    logic [REPEAT_WIDTH-1:0] rep_cnt [NUM_BTN];

    logic [SPEED_W-1:0] speed_next;
    logic               speed_changed;
    state_t             state;
    state_t             state_next;
    logic [1:0]         fn_next;
    logic [SPEED_W-1:0] data_next;

    assign raw       = {btn_down, btn_up};
    assign both_held = &db;
    assign press     = db & ~db_prev;
    assign rpt_hit   = {rep_cnt[1] == REP_LAST, rep_cnt[0] == REP_LAST};
    assign rpt       = rpt_hit & db & db_prev & ~{NUM_BTN{both_held}};
    assign step      = press | rpt;

    // Synchroniser, debounce and auto-repeat timing for both buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta    <= '0;
            sync    <= '0;
            db      <= '0;
            db_prev <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i]  <= '0;
                rep_cnt[i] <= '0;
            end
        end else begin
            meta    <= raw;
            sync    <= meta;
            db_prev <= db;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_WIDTH'(1);
                end

                // Restart the repeat period on a fresh press, after each repeat, or while chorded.
                if (!db[i] || both_held || press[i] || rpt_hit[i]) begin
                    rep_cnt[i] <= '0;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + REPEAT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        speed_next = speed;
        if (step[0] && !step[1] && speed != SPEED_MAX) begin
            speed_next = speed + SPEED_W'(1);
        end else if (step[1] && !step[0] && speed != SPEED_MIN) begin
            speed_next = speed - SPEED_W'(1);
        end
    end

    assign speed_changed = (speed_next != speed);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed <= RESET_SPEED;
        end else begin
            speed <= speed_next;
        end
    end

    // Load FSM: one load after reset, then one load per speed change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_INIT;
            fn_out   <= FN_RUN;
            data_out <= RESET_SPEED;
        end else begin
            state    <= state_next;
            fn_out   <= fn_next;
            data_out <= data_next;
        end
    end

    always_comb begin
        state_next = state;
        fn_next    = FN_RUN;
        data_next  = data_out;
        case (state)
            ST_INIT: begin
                state_next = ST_IDLE;
                fn_next    = FN_LOAD;
                data_next  = speed_next;
            end
            ST_IDLE: begin
                if (speed_changed) begin
                    fn_next   = FN_LOAD;
                    data_next = speed_next;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end
endmodule

// File: tb/tb_spinner_speed_ctrl.sv
// Directed bench for spinner_speed_ctrl: a cycle model built from the button timing rules
// is compared every cycle, plus hand-computed checkpoints for each scenario.
module tb_spinner_speed_ctrl;
    localparam int unsigned DB = 4;
    localparam int unsigned RP = 8;
    localparam int unsigned RS = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic [1:0] fn_out;
    logic [3:0] data_out;
    logic [3:0] speed;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    spinner_speed_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_WIDTH      (3),
        .REPEAT_CYCLES  (RP),
        .REPEAT_WIDTH   (4),
        .RESET_SPEED    (4'(RS))
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .fn_out  (fn_out),
        .data_out(data_out),
        .speed   (speed)
    );

    function automatic void check(string nm, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endfunction

    // Model state: raw pipeline, run of disagreeing samples, press anchor edge per button.
    bit rq[2][$];
    bit hist[2][$];
    bit m_db[2];
    bit m_dbp[2];
    int anchor[2];
    int tcnt;
    int m_speed;
    int e_fn;
    int e_data;
    bit m_init;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            rq[i].delete();
            rq[i].push_back(1'b0);
            rq[i].push_back(1'b0);
            hist[i].delete();
            m_db[i]   = 1'b0;
            m_dbp[i]  = 1'b0;
            anchor[i] = 0;
        end
        tcnt    = 0;
        m_speed = RS;
        e_fn    = 0;
        e_data  = RS;
        m_init  = 1'b1;
    endfunction

    function automatic void model_edge();
        bit raw[2];
        bit stp[2];
        bit nxt[2];
        bit both;
        int nspd;
        raw[0] = btn_up;
        raw[1] = btn_down;
        tcnt++;
        both = m_db[0] && m_db[1];
        for (int i = 0; i < 2; i++) begin
            bit press;
            bit rep;
            bit sy;
            press = m_db[i] && !m_dbp[i];
            rep   = m_db[i] && m_dbp[i] && !both && (tcnt > anchor[i])
                    && (((tcnt - anchor[i]) % RP) == 0);
            stp[i] = press || rep;
            if (press || both) anchor[i] = tcnt;
            // Debounced state flips after DB consecutive synchronised samples disagree with it.
            sy = rq[i].pop_front();
            rq[i].push_back(raw[i]);
            if (sy == m_db[i]) hist[i].delete();
            else hist[i].push_back(sy);
            nxt[i] = m_db[i];
            if (hist[i].size() == DB) begin
                nxt[i] = !m_db[i];
                hist[i].delete();
            end
        end
        nspd = m_speed;
        if (stp[0] && !stp[1]) nspd = (m_speed < 15) ? m_speed + 1 : 15;
        else if (stp[1] && !stp[0]) nspd = (m_speed > 0) ? m_speed - 1 : 0;
        if (m_init) begin
            e_fn   = 1;
            e_data = nspd;
            m_init = 1'b0;
        end else if (nspd != m_speed) begin
            e_fn   = 1;
            e_data = nspd;
        end else begin
            e_fn = 0;
        end
        m_speed = nspd;
        for (int i = 0; i < 2; i++) begin
            m_dbp[i] = m_db[i];
            m_db[i]  = nxt[i];
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_edge();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_fn_out", int'(fn_out), e_fn);
            check("cyc_data_out", int'(data_out), e_data);
            check("cyc_speed", int'(speed), m_speed);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cycles(3);
        check("rst_fn", int'(fn_out), 0);
        check("rst_data", int'(data_out), 8);
        check("rst_speed", int'(speed), 8);
        chk_en = 1'b1;

        // Initial load after reset release
        reset = 1'b1;
        cycles(1);
        check("init_fn", int'(fn_out), 1);
        check("init_data", int'(data_out), 8);
        cycles(1);
        check("init_once_fn", int'(fn_out), 0);
        cycles(5);

        // Short glitch, then a 20-cycle hold with two repeats
        btn_up = 1'b1;
        cycles(3);
        btn_up = 1'b0;
        cycles(12);
        check("glitch_speed", int'(speed), 8);
        btn_up = 1'b1;
        cycles(6);
        check("press_pre_speed", int'(speed), 8);
        cycles(1);
        check("press_speed", int'(speed), 9);
        check("press_fn", int'(fn_out), 1);
        check("press_data", int'(data_out), 9);
        cycles(1);
        check("press_once_fn", int'(fn_out), 0);
        cycles(7);
        check("rep1_speed", int'(speed), 10);
        cycles(5);
        btn_up = 1'b0;
        cycles(3);
        check("rep2_speed", int'(speed), 11);
        cycles(20);
        check("release_speed", int'(speed), 11);

        // Saturate high
        btn_up = 1'b1;
        cycles(80);
        check("sat_hi_speed", int'(speed), 15);
        check("sat_hi_data", int'(data_out), 15);
        btn_up = 1'b0;
        cycles(20);

        // Saturate low
        btn_down = 1'b1;
        cycles(160);
        check("sat_lo_speed", int'(speed), 0);
        check("sat_lo_data", int'(data_out), 0);
        btn_down = 1'b0;
        cycles(20);

        // Single press to 1, then both buttons together
        btn_up = 1'b1;
        cycles(8);
        btn_up = 1'b0;
        cycles(20);
        check("single_press_speed", int'(speed), 1);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        cycles(40);
        check("chord_speed", int'(speed), 1);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cycles(20);
        check("chord_release_speed", int'(speed), 1);

        // Reset in the middle of a repeat count
        btn_up = 1'b1;
        cycles(18);
        check("pre_rst_speed", int'(speed), 3);
        #2 reset = 1'b0;
        #1;
        check("async_rst_speed", int'(speed), 8);
        check("async_rst_fn", int'(fn_out), 0);
        check("async_rst_data", int'(data_out), 8);
        cycles(2);
        reset = 1'b1;
        cycles(1);
        check("reinit_fn", int'(fn_out), 1);
        check("reinit_data", int'(data_out), 8);
        cycles(5);
        check("redebounce_pre_speed", int'(speed), 8);
        cycles(1);
        check("redebounce_speed", int'(speed), 9);
        check("redebounce_fn", int'(fn_out), 1);
        btn_up = 1'b0;
        cycles(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spinner_speed_ctrl.md
# spinner_speed_ctrl

- Sits directly upstream of the 7-segment spinner stage and produces its `fn`/`data` command inputs.
- Synchronises and debounces two raw push-buttons (faster/slower) and keeps a saturating 4-bit speed code.
- On every speed change it issues a one-cycle load command (`fn_out = 2'b01`, `data_out = speed`).
- After reset release it issues one initial load so the spinner starts at a known speed.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1000: consecutive cycles a synchronised button must differ from its debounced state before that state flips (≥ 2).
- `CNT_WIDTH`, default 10: width of the debounce counters; must hold `DEBOUNCE_CYCLES-1`.
- `REPEAT_CYCLES`, default 500000: auto-repeat period while a single button is held (≥ 2).
- `REPEAT_WIDTH`, default 20: width of the repeat counter; must hold `REPEAT_CYCLES-1`.
- `RESET_SPEED`, default 4'd8: speed code after reset.

Ports:
- `clk` input 1: the single clock. All logic is rising-edge.
- `reset` input 1: asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to `clk` at the system level.
- `btn_up` input 1: raw asynchronous button, active-high; each step increments speed.
- `btn_down` input 1: raw asynchronous button, active-high; each step decrements speed.
- `fn_out` output 2: spinner function code. `2'b01` means load; `2'b00` means run. No other values are driven.
- `data_out` output 4: speed code accompanying a load.
- `speed` output 4: current speed register, for debug.

## Operation

Synchronisation
- Each button passes through a 2-flop synchroniser, giving `s_up` and `s_dn`.

Debounce, per button
- Keeps a debounced state `db` and a counter.
- Counter clears on any edge where synchroniser output == `db`.
- On an edge where they differ:
  - if counter == `DEBOUNCE_CYCLES-1`: `db` flips and counter clears;
  - otherwise the counter increments.

Step events, per button
- A press event fires in the cycle where `db` = 1 and its registered previous value = 0.
- Repeat counter clears on the edge `db` rises.
- While `db` stays 1 it increments. At `REPEAT_CYCLES-1` it fires a repeat event and clears.
- It holds at 0 while `db` = 0.
- While both `db` are 1, repeat events for both buttons are suppressed and both repeat counters held at 0.
- A step is a press event or a repeat event.

Speed update
- Up step only: `speed` +1, saturating at 15.
- Down step only: `speed` −1, saturating at 0.
- Up and down steps in the same cycle: no change.
- A saturated step, e.g. up at 15, causes no change and no load.

Load FSM, states INIT / IDLE
- INIT (reset state): next edge goes to IDLE with `fn_out` <= 01 and `data_out` <= `speed`.
- IDLE, edge where `speed` changes: `fn_out` <= 01 and `data_out` <= new speed, registered in the same edge as `speed`.
- IDLE, any other edge: `fn_out` <= 00; `data_out` holds its value.

## Timing

Reset values
- `fn_out` = 00, `data_out` = `RESET_SPEED`, `speed` = `RESET_SPEED`.
- FSM in INIT; all `db`, counters and synchronisers are 0.

Initial load
- `fn_out` = 01 for exactly the one cycle after the first edge following reset release.

Press latency
- Raw input held high from before edge 0:
  - `db` rises after edge `DEBOUNCE_CYCLES+1`;
  - `speed`/`fn_out` update at edge `DEBOUNCE_CYCLES+2`.
- Repeat steps follow every `REPEAT_CYCLES` edges after that.

Glitches
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no `db` change.

Load timing
- `fn_out` = 01 never lasts more than one cycle per change.
- Back-to-back changes on consecutive edges give consecutive 01 cycles, each carrying its own `data_out`.
- `data_out` is stable in every cycle where `fn_out` = 01.

Release
- Releasing a button is also debounced. It causes no step.

Reset assertion mid-operation
- Outputs return to reset values immediately, without waiting for a clock edge.
- Any pending repeat or debounce count is discarded.

## Test plan

Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `REPEAT_CYCLES`=8, `RESET_SPEED`=8.

1. Release reset, buttons low -> `fn_out`=01 with `data_out`=8 for exactly one cycle, then 00 indefinitely.
2. `btn_up` pulse of 3 cycles -> no `db` change, `speed` stays 8, no load. Then a 20-cycle hold -> `speed`=9 with a one-cycle load of `data_out`=9, six edges after the raw rise (`DEBOUNCE_CYCLES`+2), followed by repeat steps to 10 and 11 at 8-cycle spacing.
3. Hold `btn_up` long enough to exceed 15 -> `speed` saturates at 15. Further repeat ticks produce no `fn_out`=01.
4. Drive `speed` to 0 with `btn_down`, keep holding -> no further loads, and `data_out` holds at 0.
5. `btn_up` and `btn_down` raised on the same cycle and held 40 cycles -> press events cancel, no repeats, `speed` unchanged, no load.
6. Hold `btn_up` through a repeat, assert `reset` mid-count -> outputs return to reset values immediately. After release: the initial load of 8, then a fresh full debounce delay before the next step.
